// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared state encoding and word width for the boot loader
package imem_boot_loader_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [2:0] {
      LEN_HI  = 3'd0,
      LEN_LO  = 3'd1,
      DATA_HI = 3'd2,
      DATA_LO = 3'd3,
      CHECK   = 3'd4,
      DONE    = 3'd5,
      ERROR   = 3'd6
   } state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream image loader writing 16-bit words into instruction memory
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int unsigned       IMEM_DEPTH = 256,
   parameter logic [WORD_W-1:0] BASE_ADDR  = 16'h0000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [WORD_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error
);

   localparam logic [WORD_W:0] DEPTH_LIM = (WORD_W + 1)'(IMEM_DEPTH);

   state_t            state_r;
   state_t            state_nxt;
   logic [7:0]        hi_byte;
   logic [7:0]        checksum;
   logic [WORD_W-1:0] word_count;
   logic [WORD_W-1:0] index;
   logic              accept;
   logic              rearm;
   logic [WORD_W-1:0] len_word;

   assign accept   = byte_valid && byte_ready;
   assign rearm    = start && (state_r == DONE || state_r == ERROR);
   assign len_word = {hi_byte, byte_data};

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r <= LEN_HI;
      end else begin
         state_r <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_r;
      case (state_r)
         LEN_HI:  if (accept) state_nxt = LEN_LO;
         LEN_LO: begin
            if (accept) begin
               if ({1'b0, len_word} > DEPTH_LIM) state_nxt = ERROR;
               else if (len_word == '0)          state_nxt = CHECK;
               else                              state_nxt = DATA_HI;
            end
         end
         DATA_HI: if (accept) state_nxt = DATA_LO;
         DATA_LO: begin
            if (accept) state_nxt = ((index + 16'd1) == word_count) ? CHECK : DATA_HI;
         end
         CHECK:   if (accept) state_nxt = (byte_data == checksum) ? DONE : ERROR;
         DONE:    if (start) state_nxt = LEN_HI;
         ERROR:   if (start) state_nxt = LEN_HI;
         default: state_nxt = LEN_HI;
      endcase
   end

   always_comb begin
      byte_ready = 1'b1;
      cpu_hold   = 1'b1;
      load_done  = 1'b0;
      load_error = 1'b0;
      case (state_r)
         DONE: begin
            byte_ready = 1'b0;
            cpu_hold   = 1'b0;
            load_done  = 1'b1;
         end
         ERROR: begin
            byte_ready = 1'b0;
            load_error = 1'b1;
         end
         default: ;
      endcase
   end

   // The checksum byte itself is excluded from the running XOR it is compared against.
   always_ff @(posedge clock) begin
      if (!reset) begin
         checksum <= '0;
      end else if (rearm) begin
         checksum <= '0;
      end else if (accept && state_r != CHECK) begin
         checksum <= checksum ^ byte_data;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         hi_byte    <= '0;
         word_count <= '0;
         index      <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         if (rearm) index <= '0;
         if (accept) begin
            case (state_r)
               LEN_HI:  hi_byte    <= byte_data;
               LEN_LO:  word_count <= len_word;
               DATA_HI: hi_byte    <= byte_data;
               DATA_LO: begin
                  imem_we    <= 1'b1;
                  imem_addr  <= BASE_ADDR + index;
                  imem_wdata <= len_word;
                  index      <= index + 16'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
